// File: rtl/instr_fetch_unit_if.sv
// Control-strobe and instruction-memory bundle between the control state machine (master) and instr_fetch_unit (slave).
// The FETCH_PERF_CNT_EN macro adds the fetch_count/jump_count observation signals.
`ifndef MEM_MIDR_M_CI
`define MEM_MIDR_M_CI 3'd2
`endif
`ifndef PRM_JMP
`define PRM_JMP 2'd1
`endif
`ifndef OPR_PC
`define OPR_PC 3'd4
`endif
`ifndef JMP_JUMP
`define JMP_JUMP 4'd0
`endif
`ifndef JMP_Z
`define JMP_Z 4'd1
`endif
`ifndef JMP_NZ
`define JMP_NZ 4'd2
`endif

interface instr_fetch_unit_if #(parameter int PC_W = 8);
  logic            status;
  logic            PCI;
  logic [2:0]      MEM;
  logic [1:0]      PRM;
  logic [3:0]      PRM_param;
  logic [2:0]      OPR;
  logic            zero;
  logic [7:0]      imem_rdata;
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      MIDR;
  logic [PC_W-1:0] PC;
  logic            jump_taken;
  logic            pc_wrap;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]     fetch_count;
  logic [15:0]     jump_count;

  modport master (
    output status, PCI, MEM, PRM, PRM_param, OPR, zero, imem_rdata,
    input  imem_addr, MIDR, PC, jump_taken, pc_wrap, fetch_count, jump_count
  );
  modport slave (
    input  status, PCI, MEM, PRM, PRM_param, OPR, zero, imem_rdata,
    output imem_addr, MIDR, PC, jump_taken, pc_wrap, fetch_count, jump_count
  );
`else
  modport master (
    output status, PCI, MEM, PRM, PRM_param, OPR, zero, imem_rdata,
    input  imem_addr, MIDR, PC, jump_taken, pc_wrap
  );
  modport slave (
    input  status, PCI, MEM, PRM, PRM_param, OPR, zero, imem_rdata,
    output imem_addr, MIDR, PC, jump_taken, pc_wrap
  );
`endif
endinterface

// File: rtl/instr_fetch_unit.sv
// PC / MIDR stage: fetches bytes from async-read imem and applies increment and jump strobes on posedge.
// Define FETCH_PERF_CNT_EN to add saturating fetch_count and jump_count outputs.
module instr_fetch_unit #(
  parameter int              PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input logic                 clock,
  input logic                 reset,
  instr_fetch_unit_if.slave   bus
);

  logic [PC_W-1:0] pc_q;
  logic [7:0]      midr_q;
  logic            jump_taken_q;
  logic            pc_wrap_q;

  logic            fetch_go;
  logic            jump_req;
  logic            cond_ok;
  logic            jump_go;
  logic [PC_W+7:0] midr_ext;
  logic [PC_W-1:0] jump_target;

  always_comb begin
    fetch_go = bus.status && (bus.MEM == `MEM_MIDR_M_CI);
    jump_req = bus.status && (bus.PRM == `PRM_JMP) && (bus.OPR == `OPR_PC);
    case (bus.PRM_param)
      `JMP_JUMP: cond_ok = 1'b1;
      `JMP_Z:    cond_ok = bus.zero;
      `JMP_NZ:   cond_ok = !bus.zero;
      default:   cond_ok = 1'b0;
    endcase
    jump_go = jump_req && cond_ok;
    // Works for both narrow (truncate) and wide (zero-extend) PC
    midr_ext    = {{PC_W{1'b0}}, midr_q};
    jump_target = midr_ext[PC_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q         <= RST_PC;
      midr_q       <= 8'h00;
      jump_taken_q <= 1'b0;
      pc_wrap_q    <= 1'b0;
    end else if (!bus.status) begin
      pc_q         <= RST_PC;
      midr_q       <= 8'h00;
      jump_taken_q <= 1'b0;
    end else begin
      jump_taken_q <= jump_go;
      if (fetch_go) begin
        midr_q <= bus.imem_rdata;
      end
      if (jump_go) begin
        pc_q <= jump_target;
      end else if (bus.PCI) begin
        pc_q <= pc_q + PC_W'(1);
        if (pc_q == {PC_W{1'b1}}) begin
          pc_wrap_q <= 1'b1;
        end
      end
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.PC         = pc_q;
  assign bus.MIDR       = midr_q;
  assign bus.jump_taken = jump_taken_q;
  assign bus.pc_wrap    = pc_wrap_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q;
  logic [15:0] jump_count_q;

  // Counters are gated by fetch_go/jump_go, which already include status, so idle holds them
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count_q <= 16'h0000;
      jump_count_q  <= 16'h0000;
    end else begin
      if (fetch_go && (fetch_count_q != 16'hFFFF)) begin
        fetch_count_q <= fetch_count_q + 16'd1;
      end
      if (jump_go && (jump_count_q != 16'hFFFF)) begin
        jump_count_q <= jump_count_q + 16'd1;
      end
    end
  end

  assign bus.fetch_count = fetch_count_q;
  assign bus.jump_count  = jump_count_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-counter and instruction-register stage feeding the control state machine.
- Holds the PC and presents it to the asynchronous-read instruction memory.
- Captures the fetched byte into MIDR.
- Applies PC increment and jump loads, all driven by the control strobes the state machine issues on the negative edge.
- Updates on the positive edge of the same clock, so every strobe is acted on half a cycle after it is issued.

Parameters:
- PC_W, 8, width of PC and of imem_addr; PC wraps modulo 2^PC_W.
- RST_PC, 0, PC value after reset and while status is low.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- status  input  1  run flag from state machine; low = idle (END state).
- PCI  input  1  PC increment strobe.
- MEM  input  3  memory op code; only `mem_midr_m_ci is decoded here.
- PRM  input  2  parameter-source select; only `prm_jmp is decoded here.
- PRM_param  input  4  jump condition code.
- OPR  input  3  operation select; only `opr_pc is decoded here.
- zero  input  1  ALU zero flag.
- imem_rdata  input  8  instruction memory read data (combinational from imem_addr).
- imem_addr  output  PC_W  instruction memory address, equal to PC.
- MIDR  output  8  instruction/operand register.
- PC  output  PC_W  program counter.
- jump_taken  output  1  one-cycle pulse when a jump loads PC.
- pc_wrap  output  1  sticky flag: PC incremented past 2^PC_W-1.

Behaviour:
- Reset (synchronous, highest priority): PC=RST_PC, MIDR=0, jump_taken=0, pc_wrap=0.
- Idle (status=0, reset=0):
  - PC=RST_PC, MIDR=0, jump_taken=0.
  - pc_wrap holds its value.
  - All strobes are ignored, including the END state's jump strobes.
- Fetch:
  - Condition: status=1 and MEM==`mem_midr_m_ci.
  - Action: MIDR <= imem_rdata on the posedge, with the read address being the PC value before that edge.
  - Otherwise MIDR holds.
- Increment:
  - Condition: status=1, PCI=1, and no jump this cycle.
  - Action: PC <= PC+1 (mod 2^PC_W).
  - If PC was 2^PC_W-1, PC becomes 0 and pc_wrap is set; it clears only on reset.
- Jump request:
  - Condition: status=1, PRM==`prm_jmp and OPR==`opr_pc.
  - Target: MIDR[PC_W-1:0], zero-extended if PC_W>8.
- Jump condition on PRM_param:
  - `jmp_jump (4'd0): always taken.
  - `jmp_z (4'd1): taken if zero=1.
  - `jmp_nz (4'd2): taken if zero=0.
  - Any other code: never taken; PC holds unless PCI=1.
- Taken jump: PC <= target and jump_taken=1 for exactly one cycle. Otherwise jump_taken=0.
- Priority: reset > idle > jump > increment.
- Same-cycle fetch and jump: MIDR captures the byte at the old PC; PC takes the jump target.
- Fetch and increment are independent and both occur in the same cycle: the normal FETCH_2/operand pattern.
- imem_addr = PC combinationally; zero added latency.
- Back-to-back strobes every cycle are supported; no stall or handshake.
- Reset mid-instruction aborts cleanly; the state machine restarts from END.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two 16-bit outputs, fetch_count and jump_count:
  - Both reset to 0 on reset.
  - fetch_count increments on each fetch.
  - jump_count increments on each taken jump.
  - Both saturate at 16'hFFFF.
  - Both hold while status=0; they are not cleared by idle.
- When undefined, neither port nor the counters exist.
- Core behaviour is identical either way.

Test Plan:
- Reset and start:
  - Stimulus: reset=1 for 2 cycles, then status=1.
  - Required: PC=0, MIDR=0, pc_wrap=0; imem_addr=0.
- Sequential fetch:
  - Stimulus: imem[0..2]=8'h10,8'h2A,8'h30; MEM=`mem_midr_m_ci with PCI=1 on 3 consecutive cycles.
  - Required: MIDR=8'h10, 8'h2A, 8'h30 in turn; PC=1, 2, 3.
- Unconditional jump:
  - Stimulus: MIDR=8'h40, PRM=`prm_jmp, OPR=`opr_pc, PRM_param=0.
  - Required: PC=8'h40 next cycle; jump_taken high for exactly 1 cycle.
- Conditional jump:
  - Stimulus: PRM_param=1 with zero=0, then zero=1, MIDR=8'h55.
  - Required: first jump not taken and PC unchanged; second gives PC=8'h55.
  - Stimulus: PRM_param=2 with zero=1.
  - Required: not taken.
- Wrap and precedence:
  - Stimulus: PC=8'hFF, then PCI=1.
  - Required: PC=0 and pc_wrap=1.
  - Stimulus: PCI=1 together with a taken jump to 8'h20.
  - Required: PC=8'h20.
- Idle and mid-run reset:
  - Stimulus: status drops to 0 with PC=8'h33.
  - Required: PC=0 and MIDR=0 on the next edge; jump strobes ignored.
  - Stimulus: reset asserted during a fetch.
  - Required: MIDR=0, no capture.
